// File: rtl/skeleton_seg_scheduler.sv
// Takes frames captured by the SPI receiver, holds them in a pending buffer, and at vertical blanking
// turns the P1-P2, P2-P3 and P3-P4 skeleton segments into valid/ready line requests.
module skeleton_seg_scheduler #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             done,
  input  logic [127:0]     frame_data,
  input  logic             vsync_start,
  output logic             seg_valid,
  input  logic             seg_ready,
  output logic [9:0]       seg_x0,
  output logic [9:0]       seg_y0,
  output logic [9:0]       seg_x1,
  output logic [9:0]       seg_y1,
  output logic [11:0]      seg_color,
  output logic             busy,
  output logic             frame_done,
  output logic [7:0]       overrun_cnt,
  output logic [CNT_W-1:0] frames_drawn
);

  typedef enum logic [1:0] {IDLE, SEND, NEXT} state_e;

  state_e                 state_q, state_d;
  logic [1:0]             idx_q, idx_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic                   capture;
  logic                   promote;
  logic [91:0]            pend_q, act_q;
  logic                   pend_valid_q;
  logic [7:0]             overrun_q;
  logic [CNT_W-1:0]       frames_q;
  logic [9:0]             px [4];
  logic [9:0]             py [4];
  logic                   skip;
  logic                   valid;
  logic                   fdone;
  logic                   unused_bits;

  assign unused_bits = ^frame_data[35:0];

  // Flops reset to 1 so a done already high when reset is released does not count as a rising edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '1;
      hist_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], done};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign capture = sync_q[SYNC_STAGES-1] & ~hist_q;
  assign promote = (state_q == IDLE) && vsync_start && pend_valid_q;

  // On a capture coinciding with a promotion, active takes the old pending frame and no overrun is counted.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q       <= '0;
      act_q        <= '0;
      pend_valid_q <= 1'b0;
      overrun_q    <= '0;
    end else begin
      if (promote) act_q <= pend_q;
      if (capture) begin
        pend_q       <= frame_data[127:36];
        pend_valid_q <= 1'b1;
        if (pend_valid_q && !promote && overrun_q != 8'hFF) overrun_q <= overrun_q + 8'd1;
      end else if (promote) begin
        pend_valid_q <= 1'b0;
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < 4; i++) begin
      px[i] = act_q[91 - 20*i -: 10];
      py[i] = act_q[81 - 20*i -: 10];
    end
  end

  assign skip = (px[idx_q] == 10'h3FF) || (px[idx_q + 2'd1] == 10'h3FF);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      frames_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (fdone) frames_q <= frames_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    valid   = 1'b0;
    fdone   = 1'b0;
    case (state_q)
      IDLE: begin
        if (promote) begin
          state_d = SEND;
          idx_d   = '0;
        end
      end
      SEND: begin
        if (skip) begin
          state_d = NEXT;
        end else begin
          valid = 1'b1;
          if (seg_ready) state_d = NEXT;
        end
      end
      NEXT: begin
        if (idx_q == 2'd2) begin
          fdone   = 1'b1;
          state_d = IDLE;
        end else begin
          idx_d   = idx_q + 2'd1;
          state_d = SEND;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign seg_valid    = valid;
  assign seg_x0       = valid ? px[idx_q]         : '0;
  assign seg_y0       = valid ? py[idx_q]         : '0;
  assign seg_x1       = valid ? px[idx_q + 2'd1]  : '0;
  assign seg_y1       = valid ? py[idx_q + 2'd1]  : '0;
  assign seg_color    = valid ? act_q[11:0]       : '0;
  assign busy         = (state_q != IDLE);
  assign frame_done   = fdone;
  assign overrun_cnt  = overrun_q;
  assign frames_drawn = frames_q;

endmodule

// File: tb/tb_skeleton_seg_scheduler.sv
// Bench for skeleton_seg_scheduler: an expectation-queue model of each frame's request/gap slots,
// checked every cycle, plus directed scenarios with literal expected transfers.
module tb_skeleton_seg_scheduler;

  localparam int S = 2;

  logic         clk = 1'b0;
  logic         reset;
  logic         done;
  logic [127:0] frame_data;
  logic         vsync_start;
  logic         seg_valid;
  logic         seg_ready;
  logic [9:0]   seg_x0, seg_y0, seg_x1, seg_y1;
  logic [11:0]  seg_color;
  logic         busy;
  logic         frame_done;
  logic [7:0]   overrun_cnt;
  logic [15:0]  frames_drawn;

  skeleton_seg_scheduler #(.SYNC_STAGES(S), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .done(done), .frame_data(frame_data),
    .vsync_start(vsync_start), .seg_valid(seg_valid), .seg_ready(seg_ready),
    .seg_x0(seg_x0), .seg_y0(seg_y0), .seg_x1(seg_x1), .seg_y1(seg_y1),
    .seg_color(seg_color), .busy(busy), .frame_done(frame_done),
    .overrun_cnt(overrun_cnt), .frames_drawn(frames_drawn)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [127:0] mk(input logic [9:0] x1, y1, x2, y2, x3, y3, x4, y4,
                                      input logic [3:0] r, g, b);
    return {x1, y1, x2, y2, x3, y3, x4, y4, r, g, b, 36'h0};
  endfunction

  function automatic logic [51:0] lit(input logic [9:0] x0, y0, x1, y1, input logic [11:0] c);
    return {x0, y0, x1, y1, c};
  endfunction

  function automatic logic [9:0] fx(input logic [127:0] f, input int p);
    case (p)
      0: return f[127:118];
      1: return f[107:98];
      2: return f[87:78];
      default: return f[67:58];
    endcase
  endfunction

  function automatic logic [9:0] fy(input logic [127:0] f, input int p);
    case (p)
      0: return f[117:108];
      1: return f[97:88];
      2: return f[77:68];
      default: return f[57:48];
    endcase
  endfunction

  // One slot per expected cycle class: a request (held until accepted) or a one-cycle gap.
  typedef struct {
    bit          req;
    bit          last;
    logic [51:0] data;
  } slot_t;

  slot_t        sq[$];
  logic [127:0] m_pend = '0;
  bit           m_pv = 1'b0;
  logic [7:0]   m_ovr = '0;
  logic [15:0]  m_frames = '0;
  bit           dh [S+2];
  logic [51:0]  xlog[$];
  int           fd_cnt = 0;
  int           stall_cnt = 0;

  initial for (int k = 0; k < S + 2; k++) dh[k] = 1'b1;

  task automatic build_frame(input logic [127:0] f);
    slot_t s;
    logic [11:0] col;
    col = {f[47:44], f[43:40], f[39:36]};
    for (int k = 0; k < 3; k++) begin
      s.data = lit(fx(f, k), fy(f, k), fx(f, k + 1), fy(f, k + 1), col);
      s.last = 1'b0;
      s.req  = !(fx(f, k) == 10'h3FF || fx(f, k + 1) == 10'h3FF);
      sq.push_back(s);
      s.req  = 1'b0;
      s.last = (k == 2);
      sq.push_back(s);
    end
  endtask

  always @(negedge clk) begin
    bit ev, eb, ef, cap, prom;
    ev = (sq.size() > 0) && sq[0].req;
    eb = (sq.size() > 0);
    ef = (sq.size() > 0) && !sq[0].req && sq[0].last;
    chk("seg_valid", 64'(seg_valid), 64'(ev));
    chk("busy", 64'(busy), 64'(eb));
    chk("frame_done", 64'(frame_done), 64'(ef));
    chk("overrun_cnt", 64'(overrun_cnt), 64'(m_ovr));
    chk("frames_drawn", 64'(frames_drawn), 64'(m_frames));
    if (ev) chk("seg_fields", 64'({seg_x0, seg_y0, seg_x1, seg_y1, seg_color}), 64'(sq[0].data));
    if (seg_valid && seg_ready) xlog.push_back({seg_x0, seg_y0, seg_x1, seg_y1, seg_color});
    if (seg_valid && !seg_ready) stall_cnt++;
    if (frame_done) fd_cnt++;

    for (int k = S + 1; k > 0; k--) dh[k] = dh[k-1];
    dh[0] = done;
    if (reset) for (int k = 0; k < S + 2; k++) dh[k] = 1'b1;
    cap = dh[S] && !dh[S+1];

    if (reset) begin
      sq.delete();
      m_pv = 1'b0;
      m_ovr = '0;
      m_frames = '0;
    end else begin
      prom = (sq.size() == 0) && vsync_start && m_pv;
      if (sq.size() > 0) begin
        if (sq[0].req) begin
          if (seg_ready) void'(sq.pop_front());
        end else begin
          if (sq[0].last) m_frames++;
          void'(sq.pop_front());
        end
      end
      if (prom) build_frame(m_pend);
      if (cap) begin
        if (m_pv && !prom && m_ovr != 8'hFF) m_ovr++;
        m_pend = frame_data;
        m_pv = 1'b1;
      end else if (prom) begin
        m_pv = 1'b0;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic capture_frame(input logic [127:0] f);
    frame_data = f;
    done = 1'b1;
    tick(4);
    done = 1'b0;
    tick(4);
  endtask

  task automatic vsync_pulse();
    vsync_start = 1'b1;
    tick(1);
    vsync_start = 1'b0;
  endtask

  int base, fd0, st0;

  initial begin
    reset = 1'b1; done = 1'b1; frame_data = '0; vsync_start = 1'b0; seg_ready = 1'b1;
    tick(3);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_valid", 64'(seg_valid), 64'd0);
    chk("rst_overrun", 64'(overrun_cnt), 64'd0);
    chk("rst_frames", 64'(frames_drawn), 64'd0);
    reset = 1'b0;
    tick(5);
    vsync_pulse();
    chk("empty_vsync_busy", 64'(busy), 64'd0);
    done = 1'b0;
    tick(4);

    // Basic frame, rasterizer always ready
    capture_frame(mk(10, 5, 20, 6, 30, 7, 40, 8, 4'hF, 4'h0, 4'hA));
    base = xlog.size(); fd0 = fd_cnt;
    vsync_pulse();
    tick(10);
    chk("t1_count", 64'(xlog.size() - base), 64'd3);
    chk("t1_seg0", 64'(xlog[base]),     64'(lit(10, 5, 20, 6, 12'hF0A)));
    chk("t1_seg1", 64'(xlog[base + 1]), 64'(lit(20, 6, 30, 7, 12'hF0A)));
    chk("t1_seg2", 64'(xlog[base + 2]), 64'(lit(30, 7, 40, 8, 12'hF0A)));
    chk("t1_fdone", 64'(fd_cnt - fd0), 64'd1);
    chk("t1_frames", 64'(frames_drawn), 64'd1);

    // Stall segment 0 for 5 cycles
    capture_frame(mk(100, 50, 200, 60, 300, 70, 400, 80, 4'h1, 4'h2, 4'h3));
    base = xlog.size(); st0 = stall_cnt;
    seg_ready = 1'b0;
    vsync_pulse();
    tick(2);
    chk("stall_valid", 64'(seg_valid), 64'd1);
    chk("stall_x0", 64'(seg_x0), 64'd100);
    chk("stall_y1", 64'(seg_y1), 64'd60);
    tick(3);
    seg_ready = 1'b1;
    tick(10);
    chk("stall_cycles", 64'(stall_cnt - st0), 64'd5);
    chk("stall_count", 64'(xlog.size() - base), 64'd3);
    chk("stall_seg0", 64'(xlog[base]), 64'(lit(100, 50, 200, 60, 12'h123)));

    // Invalid joint P3: only P1-P2 issued
    capture_frame(mk(1, 2, 3, 4, 10'h3FF, 6, 7, 8, 4'h5, 4'h5, 4'h5));
    base = xlog.size(); fd0 = fd_cnt;
    vsync_pulse();
    tick(10);
    chk("skip_count", 64'(xlog.size() - base), 64'd1);
    chk("skip_seg0", 64'(xlog[base]), 64'(lit(1, 2, 3, 4, 12'h555)));
    chk("skip_fdone", 64'(fd_cnt - fd0), 64'd1);
    chk("skip_frames", 64'(frames_drawn), 64'd3);

    // Overrun: second capture replaces the first
    capture_frame(mk(11, 12, 13, 14, 15, 16, 17, 18, 4'h9, 4'h9, 4'h9));
    capture_frame(mk(21, 22, 23, 24, 25, 26, 27, 28, 4'hA, 4'hB, 4'hC));
    chk("ovr_cnt", 64'(overrun_cnt), 64'd1);
    base = xlog.size();
    vsync_pulse();
    tick(10);
    chk("ovr_count", 64'(xlog.size() - base), 64'd3);
    chk("ovr_seg0", 64'(xlog[base]), 64'(lit(21, 22, 23, 24, 12'hABC)));

    // Capture lands on the same edge as a promotion
    capture_frame(mk(31, 32, 33, 34, 35, 36, 37, 38, 4'h1, 4'h1, 4'h1));
    base = xlog.size();
    frame_data = mk(41, 42, 43, 44, 45, 46, 47, 48, 4'h2, 4'h2, 4'h2);
    done = 1'b1;
    tick(2);
    vsync_pulse();
    tick(2);
    done = 1'b0;
    tick(10);
    chk("coin_seg0", 64'(xlog[base]), 64'(lit(31, 32, 33, 34, 12'h111)));
    chk("coin_ovr", 64'(overrun_cnt), 64'd1);
    base = xlog.size();
    vsync_pulse();
    tick(10);
    chk("coin_next_seg0", 64'(xlog[base]), 64'(lit(41, 42, 43, 44, 12'h222)));
    chk("coin_frames", 64'(frames_drawn), 64'd6);

    // Reset during segment 1 with a pending frame and done held high
    capture_frame(mk(51, 52, 53, 54, 55, 56, 57, 58, 4'h3, 4'h3, 4'h3));
    base = xlog.size();
    frame_data = mk(61, 62, 63, 64, 65, 66, 67, 68, 4'h4, 4'h4, 4'h4);
    done = 1'b1;
    vsync_pulse();
    tick(2);
    chk("rs_seg1_valid", 64'(seg_valid), 64'd1);
    chk("rs_seg1_x0", 64'(seg_x0), 64'd53);
    seg_ready = 1'b0;
    reset = 1'b1;
    tick(1);
    chk("rs_valid", 64'(seg_valid), 64'd0);
    chk("rs_busy", 64'(busy), 64'd0);
    tick(1);
    reset = 1'b0;
    seg_ready = 1'b1;
    tick(5);
    vsync_pulse();
    tick(2);
    chk("rs_vsync_busy", 64'(busy), 64'd0);
    chk("rs_count", 64'(xlog.size() - base), 64'd1);
    chk("rs_frames", 64'(frames_drawn), 64'd0);
    done = 1'b0;
    tick(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
